// File: rtl/mc_ctrl_hs_if.sv
// rtl/mc_ctrl_hs_if.sv - request/ready handshake bundle between the controller and the instruction/data memories
interface mc_ctrl_hs_if;
   logic imem_req;
   logic imem_ready;
   logic mem_rd;
   logic mem_wr;
   logic byte_en;
   logic dmem_ready;

   modport master (
      output imem_req, mem_rd, mem_wr, byte_en,
      input  imem_ready, dmem_ready
   );

   modport slave (
      input  imem_req, mem_rd, mem_wr, byte_en,
      output imem_ready, dmem_ready
   );
endinterface

// File: rtl/mc_ctrl_hs.sv
// rtl/mc_ctrl_hs.sv - multicycle MIPS control unit with variable-latency memory handshakes
// Optional macro ILLEGAL_TRAP_EN: illegal instructions halt in TRAP instead of retiring as NOP.
module mc_ctrl_hs #(
   parameter int CNT_W    = 32,
   parameter int WAIT_MAX = 8
) (
   input  logic             clk,
   input  logic             rst,
   mc_ctrl_hs_if.master     io_mem,
   input  logic [31:0]      i_instr,
   input  logic             i_zero,
   output logic             o_ir_wr,
   output logic             o_pc_wr,
   output logic             o_reg_wr,
   output logic [1:0]       o_reg_dst,
   output logic [1:0]       o_wb_sel,
   output logic             o_alu_src,
   output logic [1:0]       o_ext_op,
   output logic [1:0]       o_npc_sel,
   output logic [3:0]       o_alu_ctr,
   output logic [2:0]       o_state,
   output logic             o_bus_err,
   output logic [CNT_W-1:0] o_instr_cnt,
   output logic             o_trap
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_DCD  = 3'd1,
      S_EXE  = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_TRAP = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09, OP_ORI  = 6'h0D, OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20, OP_LW   = 6'h23, OP_SB    = 6'h28, OP_SW = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08, FN_JALR = 6'h09, FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23, FN_SLT  = 6'h2A;

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_OR = 4'd2, ALU_SLT = 4'd4;
   localparam logic [1:0] EXT_SIGN = 2'd1, EXT_LUI = 2'd2;
   localparam logic [1:0] NPC_SEQ = 2'd0, NPC_BR = 2'd1, NPC_JUMP = 2'd2, NPC_REG = 2'd3;
   localparam logic [1:0] WB_MEM = 2'd1, WB_PC4 = 2'd2;
   localparam logic [1:0] RD_RD = 2'd1, RD_RA = 2'd2;

`ifdef ILLEGAL_TRAP_EN
   localparam state_t S_ILLEGAL = S_TRAP;
`else
   localparam state_t S_ILLEGAL = S_IF;
`endif

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_instr_cnt;
   logic [7:0]       r_wait;
   logic             r_bus_err;

   logic w_imem_req, w_mem_rd, w_mem_wr, w_byte_en;
   logic w_waiting;

   wire [5:0] w_op    = i_instr[31:26];
   wire [5:0] w_funct = i_instr[5:0];
   wire       w_unused_fields = &{1'b0, i_instr[25:6]};

   wire w_rtype = (w_op == OP_RTYPE);
   wire w_addu  = w_rtype && (w_funct == FN_ADDU);
   wire w_subu  = w_rtype && (w_funct == FN_SUBU);
   wire w_slt   = w_rtype && (w_funct == FN_SLT);
   wire w_jr    = w_rtype && (w_funct == FN_JR);
   wire w_jalr  = w_rtype && (w_funct == FN_JALR);
   wire w_j     = (w_op == OP_J);
   wire w_jal   = (w_op == OP_JAL);
   wire w_beq   = (w_op == OP_BEQ);
   wire w_bne   = (w_op == OP_BNE);
   wire w_addi  = (w_op == OP_ADDI);
   wire w_addiu = (w_op == OP_ADDIU);
   wire w_ori   = (w_op == OP_ORI);
   wire w_lui   = (w_op == OP_LUI);
   wire w_lw    = (w_op == OP_LW);
   wire w_lb    = (w_op == OP_LB);
   wire w_sw    = (w_op == OP_SW);
   wire w_sb    = (w_op == OP_SB);

   wire w_is_load   = w_lw | w_lb;
   wire w_is_store  = w_sw | w_sb;
   wire w_is_mem    = w_is_load | w_is_store;
   wire w_is_byte   = w_lb | w_sb;
   wire w_is_br     = w_beq | w_bne;
   wire w_rtype_alu = w_addu | w_subu | w_slt;
   wire w_itype_alu = w_ori | w_addi | w_addiu | w_lui;
   wire w_br_taken  = (w_beq & i_zero) | (w_bne & ~i_zero);
   wire w_legal     = w_rtype_alu | w_jr | w_jalr | w_itype_alu | w_is_mem |
                      w_is_br | w_j | w_jal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IF;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IF:  if (io_mem.imem_ready) w_next = S_DCD;
         S_DCD: begin
            if (!w_legal)   w_next = S_ILLEGAL;
            else if (w_jal) w_next = S_WB;
            else if (w_j)   w_next = S_IF;
            else            w_next = S_EXE;
         end
         S_EXE: begin
            if (w_is_br || w_jr) w_next = S_IF;
            else if (w_is_mem)   w_next = S_MEM;
            else                 w_next = S_WB;
         end
         S_MEM: if (io_mem.dmem_ready) w_next = w_is_store ? S_IF : S_WB;
         S_WB:  w_next = S_IF;
`ifdef ILLEGAL_TRAP_EN
         S_TRAP: w_next = S_TRAP;
`endif
         default: w_next = S_IF;
      endcase
   end

   always_comb begin
      o_ir_wr    = 1'b0;
      o_pc_wr    = 1'b0;
      o_reg_wr   = 1'b0;
      o_reg_dst  = 2'd0;
      o_wb_sel   = 2'd0;
      o_alu_src  = 1'b0;
      o_ext_op   = 2'd0;
      o_npc_sel  = NPC_SEQ;
      o_alu_ctr  = ALU_ADD;
      w_imem_req = 1'b0;
      w_mem_rd   = 1'b0;
      w_mem_wr   = 1'b0;
      w_byte_en  = 1'b0;
      // ALU/extender selects stay stable from EXE through WB so the datapath sees no glitch mid-access
      if (r_state == S_EXE || r_state == S_MEM || r_state == S_WB) begin
         o_alu_src = w_is_mem | w_itype_alu;
         if (w_lui) o_ext_op = EXT_LUI;
         else if (w_addi | w_addiu | w_slt | w_is_mem | w_is_br) o_ext_op = EXT_SIGN;
         if (w_subu | w_is_br) o_alu_ctr = ALU_SUB;
         else if (w_ori)       o_alu_ctr = ALU_OR;
         else if (w_slt)       o_alu_ctr = ALU_SLT;
      end
      case (r_state)
         S_IF: begin
            w_imem_req = 1'b1;
            o_ir_wr    = io_mem.imem_ready & ~rst;
         end
         S_DCD: begin
            if (!w_legal) begin
`ifndef ILLEGAL_TRAP_EN
               o_pc_wr   = 1'b1;
               o_npc_sel = NPC_SEQ;
`endif
            end else if (w_j) begin
               o_pc_wr   = 1'b1;
               o_npc_sel = NPC_JUMP;
            end
         end
         S_EXE: begin
            if (w_is_br) begin
               o_pc_wr   = 1'b1;
               o_npc_sel = w_br_taken ? NPC_BR : NPC_SEQ;
            end else if (w_jr) begin
               o_pc_wr   = 1'b1;
               o_npc_sel = NPC_REG;
            end
         end
         S_MEM: begin
            w_mem_rd  = w_is_load;
            w_mem_wr  = w_is_store;
            w_byte_en = w_is_byte;
            if (io_mem.dmem_ready && w_is_store) o_pc_wr = 1'b1;
         end
         S_WB: begin
            o_reg_wr  = 1'b1;
            o_pc_wr   = 1'b1;
            w_byte_en = w_lb;
            if (w_jal)       o_npc_sel = NPC_JUMP;
            else if (w_jalr) o_npc_sel = NPC_REG;
            if (w_jal | w_jalr) o_wb_sel = WB_PC4;
            else if (w_is_load) o_wb_sel = WB_MEM;
            if (w_jal)                      o_reg_dst = RD_RA;
            else if (w_jalr | w_rtype_alu)  o_reg_dst = RD_RD;
         end
         default: ;
      endcase
   end

   assign w_waiting = ((r_state == S_IF)  && !io_mem.imem_ready) ||
                      ((r_state == S_MEM) && !io_mem.dmem_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr_cnt <= '0;
         r_wait      <= 8'd0;
         r_bus_err   <= 1'b0;
      end else begin
         if (o_pc_wr) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
         // Counter saturates at WAIT_MAX; the flag is sticky and the FSM keeps waiting
         if (w_waiting) begin
            if (r_wait != 8'(WAIT_MAX)) r_wait <= r_wait + 8'd1;
            if (r_wait == 8'(WAIT_MAX - 1)) r_bus_err <= 1'b1;
         end else begin
            r_wait <= 8'd0;
         end
      end
   end

   assign io_mem.imem_req = w_imem_req;
   assign io_mem.mem_rd   = w_mem_rd;
   assign io_mem.mem_wr   = w_mem_wr;
   assign io_mem.byte_en  = w_byte_en;
   assign o_state         = r_state;
   assign o_bus_err       = r_bus_err;
   assign o_instr_cnt     = r_instr_cnt;
`ifdef ILLEGAL_TRAP_EN
   assign o_trap = (r_state == S_TRAP);
`else
   assign o_trap = 1'b0;
`endif

endmodule
